// File: rtl/ed_pkg.sv
// Package: ed_pkg
// Shared definitions for the receive-side deserializer.
// - ED_WORD_W    : native word width of the serial link.
// - ED_SYNC_WORD : frame alignment pattern, also used by the TX-side framing inserter.
// - deser_state_t: alignment FSM states.
package ed_pkg;

    localparam int unsigned ED_WORD_W = 16;

    localparam logic [ED_WORD_W-1:0] ED_SYNC_WORD = 16'hA5C3;

    typedef enum logic [1:0] {
        HUNT     = 2'd0,
        LOCK     = 2'd1,
        SYNC_CHK = 2'd2
    } deser_state_t;

endpackage

// File: rtl/word_fifo2.sv
// Module: word_fifo2
// Two-entry FIFO with a registered head entry, used as the output buffer of the deserializer.
// Ports:
// - clk_i       : rising-edge clock.
// - rst_ni      : asynchronous active-low reset; empties the FIFO and clears the head to 0.
// - push_i      : request to write push_data_i.
// - push_data_i : word to write.
// - push_ok_o   : the push is taken this cycle (room available, or a pop frees a full FIFO).
// - pop_i       : consumer takes the head word (ignored while empty).
// - head_o      : oldest stored word.
// - count_o     : number of stored words (0..2).
module word_fifo2 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic             push_ok_o,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic             pop_fire;
    logic             push_fire;

    assign pop_fire  = pop_i & (count_q != 2'd0);
    // A full FIFO can still take a word when the head leaves in the same cycle.
    assign push_fire = push_i & ((count_q != 2'd2) | pop_fire);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop_fire && push_fire) begin
            if (count_q == 2'd1) begin
                head_d = push_data_i;
            end else begin
                head_d = tail_q;
                tail_d = push_data_i;
            end
        end else if (pop_fire) begin
            head_d  = tail_q;
            count_d = count_q - 2'd1;
        end else if (push_fire) begin
            if (count_q == 2'd0) begin
                head_d = push_data_i;
            end else begin
                tail_d = push_data_i;
            end
            count_d = count_q + 2'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign push_ok_o = push_fire;
    assign head_o    = head_q;
    assign count_o   = count_q;

endmodule

// File: rtl/bit_deserializer_16.sv
// Module: bit_deserializer_16
// Receive-side deserializer: finds frame alignment on a sync word in a decoded serial bit stream,
// reassembles WIDTH-bit words (first received bit is the MSB) and delivers them through a
// 2-entry valid/ready buffer. Flags loss of lock and buffer overflow.
// Ports:
// - clk        : rising-edge clock.
// - reset      : asynchronous, active-low reset.
// - enb        : input enable; 0 holds all input-side state.
// - bit_in     : decoded serial bit.
// - bit_valid  : bit_in is sampled when bit_valid and enb are both 1.
// - word_out   : head word of the output buffer.
// - word_valid : word_out holds a valid word.
// - word_ready : consumer accepts word_out when word_valid is 1.
// - locked     : alignment held (LOCK or SYNC_CHK).
// - overflow   : sticky; a completed word was dropped because the buffer was full.
module bit_deserializer_16
    import ed_pkg::*;
#(
    parameter int unsigned      WIDTH       = ED_WORD_W,
    parameter logic [WIDTH-1:0] SYNC_WORD   = ED_SYNC_WORD,
    parameter int unsigned      FRAME_WORDS = 8,
    parameter int unsigned      MISS_MAX    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enb,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             locked,
    output logic             overflow
);

    localparam int unsigned BIT_CNT_W  = $clog2(WIDTH);
    localparam int unsigned WORD_CNT_W = $clog2(FRAME_WORDS + 1);
    localparam int unsigned MISS_CNT_W = $clog2(MISS_MAX + 1);
    localparam int unsigned FILL_W     = $clog2(WIDTH + 1);

    localparam logic [BIT_CNT_W-1:0]  BIT_LAST   = BIT_CNT_W'(WIDTH - 1);
    localparam logic [WORD_CNT_W-1:0] WORD_WRAP  = WORD_CNT_W'(FRAME_WORDS);
    localparam logic [MISS_CNT_W-1:0] MISS_LIMIT = MISS_CNT_W'(MISS_MAX);
    localparam logic [FILL_W-1:0]     FILL_FULL  = FILL_W'(WIDTH);
    localparam logic [FILL_W-1:0]     FILL_LAST  = FILL_W'(WIDTH - 1);

    deser_state_t          state_q, state_d;
    logic [WIDTH-1:0]      shift_q, shift_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WORD_CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [MISS_CNT_W-1:0] miss_cnt_q, miss_cnt_d;
    logic [FILL_W-1:0]     fill_q, fill_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [WIDTH-1:0]      pend_word_q, pend_word_d;
    logic                  overflow_q, overflow_d;

    logic                  accept;
    logic [WIDTH-1:0]      shift_next;
    logic                  word_done;
    logic                  hunt_armed;
    logic [WORD_CNT_W-1:0] word_cnt_inc;
    logic [MISS_CNT_W-1:0] miss_cnt_inc;

    logic                  fifo_push_ok;
    logic                  fifo_pop;
    logic [WIDTH-1:0]      fifo_head;
    logic [1:0]            fifo_count;

    assign accept       = enb & bit_valid;
    assign shift_next   = {shift_q[WIDTH-2:0], bit_in};
    assign word_done    = (bit_cnt_q == BIT_LAST);
    // The shift register starts at 0, so a match is only meaningful once WIDTH real bits are in.
    assign hunt_armed   = (fill_q >= FILL_LAST);
    assign word_cnt_inc = word_cnt_q + WORD_CNT_W'(1);
    assign miss_cnt_inc = miss_cnt_q + MISS_CNT_W'(1);

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        word_cnt_d   = word_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        fill_d       = fill_q;
        pend_valid_d = 1'b0;
        pend_word_d  = pend_word_q;
        // A word staged last cycle that the buffer refused is lost for good.
        overflow_d   = overflow_q | (pend_valid_q & ~fifo_push_ok);

        if (accept) begin
            shift_d = shift_next;
            if (fill_q != FILL_FULL) begin
                fill_d = fill_q + FILL_W'(1);
            end

            unique case (state_q)
                HUNT: begin
                    if (hunt_armed && (shift_next == SYNC_WORD)) begin
                        state_d    = LOCK;
                        bit_cnt_d  = '0;
                        word_cnt_d = '0;
                        miss_cnt_d = '0;
                    end
                end

                LOCK: begin
                    if (word_done) begin
                        bit_cnt_d    = '0;
                        pend_valid_d = 1'b1;
                        pend_word_d  = shift_next;
                        if (word_cnt_inc == WORD_WRAP) begin
                            word_cnt_d = '0;
                            state_d    = SYNC_CHK;
                        end else begin
                            word_cnt_d = word_cnt_inc;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end

                SYNC_CHK: begin
                    if (word_done) begin
                        bit_cnt_d = '0;
                        if (shift_next == SYNC_WORD) begin
                            miss_cnt_d = '0;
                            state_d    = LOCK;
                        end else begin
                            miss_cnt_d = miss_cnt_inc;
                            // Tolerate isolated sync errors; give up after MISS_MAX in a row.
                            state_d    = (miss_cnt_inc == MISS_LIMIT) ? HUNT : LOCK;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end

                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= HUNT;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            miss_cnt_q   <= '0;
            fill_q       <= '0;
            pend_valid_q <= 1'b0;
            pend_word_q  <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            word_cnt_q   <= word_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            fill_q       <= fill_d;
            pend_valid_q <= pend_valid_d;
            pend_word_q  <= pend_word_d;
            overflow_q   <= overflow_d;
        end
    end

    assign fifo_pop = word_valid & word_ready;

    word_fifo2 #(
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk_i       (clk),
        .rst_ni      (reset),
        .push_i      (pend_valid_q),
        .push_data_i (pend_word_q),
        .push_ok_o   (fifo_push_ok),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count)
    );

    assign word_out   = fifo_head;
    assign word_valid = (fifo_count != 2'd0);
    assign locked     = (state_q != HUNT);
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_bit_deserializer_16.sv
module tb_bit_deserializer_16;

    localparam logic [15:0] SYNC = 16'hA5C3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enb = 1'b1;
    logic        bit_in = 1'b0;
    logic        bit_valid = 1'b0;
    logic [15:0] word_out;
    logic        word_valid;
    logic        word_ready = 1'b1;
    logic        locked;
    logic        overflow;

    int total = 0;
    int bad = 0;

    // Reference model state (plain integers and queues)
    int          m_mode = 0;     // 0 hunting, 1 in frame, 2 checking sync
    int          m_nbits = 0;
    int          m_nwords = 0;
    int          m_miss = 0;
    int          m_seen = 0;
    logic [15:0] m_hist = '0;
    logic [15:0] m_cur = '0;
    bit          m_pend = 0;
    logic [15:0] m_pend_w = '0;
    bit          m_ovf = 0;
    logic [15:0] m_q[$];
    logic [15:0] m_got[$];
    logic [15:0] got[$];

    bit_deserializer_16 dut (
        .clk        (clk),
        .reset      (reset),
        .enb        (enb),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .locked     (locked),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int  sz;
        bit  pop;
        logic b;
        if (!reset) begin
            m_mode = 0; m_nbits = 0; m_nwords = 0; m_miss = 0; m_seen = 0;
            m_hist = '0; m_cur = '0; m_pend = 0; m_ovf = 0;
            m_q.delete();
            return;
        end
        sz  = m_q.size();
        pop = (sz > 0) && word_ready;
        if (pop) begin
            m_got.push_back(m_q[0]);
            void'(m_q.pop_front());
        end
        if (m_pend) begin
            if (sz < 2 || pop) m_q.push_back(m_pend_w);
            else m_ovf = 1;
        end
        m_pend = 0;
        if (enb && bit_valid) begin
            b = bit_in;
            m_hist = {m_hist[14:0], b};
            if (m_seen < 16) m_seen++;
            if (m_mode == 0) begin
                if (m_seen == 16 && m_hist == SYNC) begin
                    m_mode = 1; m_nbits = 0; m_nwords = 0; m_miss = 0; m_cur = '0;
                end
            end else begin
                m_cur = {m_cur[14:0], b};
                m_nbits++;
                if (m_nbits == 16) begin
                    m_nbits = 0;
                    if (m_mode == 1) begin
                        m_pend = 1;
                        m_pend_w = m_cur;
                        m_nwords++;
                        if (m_nwords == 8) begin
                            m_nwords = 0;
                            m_mode = 2;
                        end
                    end else if (m_cur == SYNC) begin
                        m_miss = 0;
                        m_mode = 1;
                    end else begin
                        m_miss++;
                        m_mode = (m_miss == 3) ? 0 : 1;
                    end
                    m_cur = '0;
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (reset && word_valid && word_ready) got.push_back(word_out);
            model_step();
        end
    end

    // Continuous compare against the model, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("cmp_valid", {31'b0, word_valid}, {31'b0, m_q.size() != 0});
                if (m_q.size() != 0) chk("cmp_word", {16'b0, word_out}, {16'b0, m_q[0]});
                chk("cmp_locked", {31'b0, locked}, {31'b0, m_mode != 0});
                chk("cmp_ovf", {31'b0, overflow}, {31'b0, m_ovf});
            end else begin
                chk("cmp_rst_out", {15'b0, word_valid, word_out}, 32'h0);
                chk("cmp_rst_flags", {30'b0, locked, overflow}, 32'h0);
            end
        end
    end

    task automatic drive(input logic b, input logic v, input logic e);
        @(negedge clk);
        #1;
        bit_in = b;
        bit_valid = v;
        enb = e;
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) drive(w[i], 1'b1, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #3;
        reset = 1'b0;
        bit_valid = 1'b0;
        #1;
        chk("rst_now_word", {16'b0, word_out}, 32'h0);
        chk("rst_now_flags", {29'b0, word_valid, locked, overflow}, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b1;
        got.delete();
        m_got.delete();
    endtask

    initial begin
        int sync_seen;
        repeat (3) @(negedge clk);
        #1;
        reset = 1'b1;
        chk("init_word", {16'b0, word_out}, 32'h0);
        chk("init_flags", {29'b0, word_valid, locked, overflow}, 32'h0);

        // Lock and first words, with output latency
        word_ready = 1'b1;
        send_word(SYNC);
        idle(1);
        chk("lock_after_sync", {31'b0, locked}, 32'h1);
        send_word(16'h0001);
        idle(1);
        chk("lat_not_yet", {31'b0, word_valid}, 32'h0);
        idle(1);
        chk("lat_valid", {31'b0, word_valid}, 32'h1);
        chk("lat_word", {16'b0, word_out}, 32'h0001);
        send_word(16'h0002);
        idle(3);
        chk("lock_count", got.size(), 2);
        if (got.size() == 2) begin
            chk("lock_w0", {16'b0, got[0]}, 32'h0001);
            chk("lock_w1", {16'b0, got[1]}, 32'h0002);
        end

        // Two full frames
        do_reset();
        send_word(SYNC);
        for (int i = 0; i < 8; i++) send_word(16'h0010 + 16'(i));
        send_word(SYNC);
        for (int i = 0; i < 8; i++) send_word(16'h0020 + 16'(i));
        idle(3);
        chk("frame_count", got.size(), 16);
        chk("model_frame_count", m_got.size(), 16);
        if (got.size() == 16) begin
            chk("frame_w0", {16'b0, got[0]}, 32'h0010);
            chk("frame_w7", {16'b0, got[7]}, 32'h0017);
            chk("frame_w8", {16'b0, got[8]}, 32'h0020);
            chk("frame_w15", {16'b0, got[15]}, 32'h0027);
        end
        if (m_got.size() == 16) chk("model_frame_w15", {16'b0, m_got[15]}, 32'h0027);
        sync_seen = 0;
        foreach (got[i]) if (got[i] == SYNC) sync_seen++;
        chk("frame_no_sync", sync_seen, 0);

        // Flywheel: two misses, good sync, two misses, third miss drops lock
        got.delete();
        send_word(16'h0000);
        for (int i = 0; i < 8; i++) send_word(16'h0030 + 16'(i));
        send_word(16'h0000);
        for (int i = 0; i < 8; i++) send_word(16'h0040 + 16'(i));
        idle(1);
        chk("fly_two_miss_locked", {31'b0, locked}, 32'h1);
        send_word(SYNC);
        for (int i = 0; i < 8; i++) send_word(16'h0050 + 16'(i));
        send_word(16'h0000);
        for (int i = 0; i < 8; i++) send_word(16'h0060 + 16'(i));
        send_word(16'h0000);
        for (int i = 0; i < 8; i++) send_word(16'h0070 + 16'(i));
        idle(1);
        chk("fly_miss_reset_locked", {31'b0, locked}, 32'h1);
        send_word(16'h0000);
        idle(1);
        chk("loss_unlocked", {31'b0, locked}, 32'h0);
        send_word(16'h1234);
        idle(3);
        chk("fly_count", got.size(), 40);
        if (got.size() == 40) begin
            chk("fly_w16", {16'b0, got[16]}, 32'h0050);
            chk("fly_w39", {16'b0, got[39]}, 32'h0077);
        end

        // Backpressure and overflow
        do_reset();
        word_ready = 1'b0;
        send_word(SYNC);
        send_word(16'h0001);
        send_word(16'h0002);
        idle(2);
        chk("bp_no_ovf_yet", {31'b0, overflow}, 32'h0);
        chk("bp_hold_word", {15'b0, word_valid, word_out}, 32'h1_0001);
        send_word(16'h0003);
        idle(2);
        chk("bp_ovf", {31'b0, overflow}, 32'h1);
        chk("bp_head_kept", {16'b0, word_out}, 32'h0001);
        word_ready = 1'b1;
        idle(4);
        chk("bp_drain_count", got.size(), 2);
        if (got.size() == 2) begin
            chk("bp_drain_w0", {16'b0, got[0]}, 32'h0001);
            chk("bp_drain_w1", {16'b0, got[1]}, 32'h0002);
        end
        chk("bp_ovf_sticky", {31'b0, overflow}, 32'h1);

        // Reset mid-transfer and mid-word
        word_ready = 1'b0;
        send_word(16'h0004);
        idle(2);
        chk("mid_held", {15'b0, word_valid, word_out}, 32'h1_0004);
        for (int i = 15; i >= 8; i--) drive(1'b1, 1'b1, 1'b1);
        do_reset();
        word_ready = 1'b1;
        idle(3);
        chk("post_rst_flags", {29'b0, word_valid, locked, overflow}, 32'h0);
        chk("post_rst_none", got.size(), 0);

        // Enable gating mid-word
        do_reset();
        send_word(SYNC);
        for (int i = 15; i >= 8; i--) drive(1'(16'hBEEF >> i), 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) drive(1'(i % 2), 1'b1, 1'b0);
        for (int i = 7; i >= 0; i--) drive(1'(16'hBEEF >> i), 1'b1, 1'b1);
        idle(3);
        chk("enb_count", got.size(), 1);
        if (got.size() == 1) chk("enb_word", {16'b0, got[0]}, 32'h0000BEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
